shift_add_multiplier_8bit: RTL

SHIFT_ADD_MULTIPLIER_8BIT -- requirements
Module: shift_add_multiplier_8bit

---
 rtl/shift_add_multiplier_8bit_pkg.sv | 18 +
 rtl/shift_add_multiplier_8bit_adder.sv | 21 ++
 rtl/shift_add_multiplier_8bit.sv | 104 ++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_8bit_pkg.sv
// Shared constants and state encoding for the 8x8 shift-and-add multiplier.
package shift_add_multiplier_8bit_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int ITER_N = 8;
    localparam int CNT_W  = 3;

    // Count value of the final iteration step.
    localparam logic [CNT_W-1:0] LAST_CNT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_multiplier_8bit_adder.sv
// 16-bit ripple-carry adder used as the accumulate stage of the multiplier.
module RippleCarryAdder_16bit (
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    logic [16:0] carry_s;

    assign carry_s[0] = c_in;

    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign sum[i]       = in1[i] ^ in2[i] ^ carry_s[i];
        assign carry_s[i+1] = (in1[i] & in2[i]) | (carry_s[i] & (in1[i] ^ in2[i]));
    end

    assign c_out = carry_s[16];

endmodule

// File: rtl/shift_add_multiplier_8bit.sv
// Sequential 8x8 unsigned shift-and-add multiplier (IDLE -> RUN -> DONE).
// Optional feature: define MULT_EARLY_TERM_EN to leave RUN as soon as the
// remaining multiplier bits are all zero; products are unchanged either way.
module shift_add_multiplier_8bit
    import shift_add_multiplier_8bit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] product,
    output logic              busy,
    output logic              done
);

    state_t              state_q, state_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [PROD_W-1:0]   mcand_q, mcand_d;
    logic [OP_W-1:0]     mplr_q, mplr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PROD_W-1:0]   sum_s;
    logic                adder_cout_unused_s;
    logic                last_step_s;

    // Carry-out is dropped: an 8x8 product always fits in 16 bits.
    RippleCarryAdder_16bit u_adder (
        .in1   (acc_q),
        .in2   (mcand_q),
        .c_in  (1'b0),
        .sum   (sum_s),
        .c_out (adder_cout_unused_s)
    );

`ifdef MULT_EARLY_TERM_EN
    // Stop once the shifted multiplier has no set bits left, or at the last step.
    assign last_step_s = (count_q == LAST_CNT) || (mplr_q[OP_W-1:1] == 7'd0);
`else
    // Fixed-latency build: always run all eight steps.
    assign last_step_s = (count_q == LAST_CNT);
`endif

    assign product = acc_q;
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    acc_d   = 16'h0000;
                    mcand_d = {8'h00, a};
                    mplr_d  = b;
                    count_d = 3'd0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (mplr_q[0]) begin
                    acc_d = sum_s;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d = {mcand_q[PROD_W-2:0], 1'b0};
                mplr_d  = {1'b0, mplr_q[OP_W-1:1]};
                count_d = count_q + 3'd1;
                if (last_step_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= 16'h0000;
            mcand_q <= 16'h0000;
            mplr_q  <= 8'h00;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            count_q <= count_d;
        end
    end

endmodule
